pwm_audio_decoder: RTL

//  Receive-side counterpart of the PWM / first-order sigma-delta audio output. Recovers 8-bit samples

---
 rtl/pwm_audio_decoder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pwm_audio_decoder.sv
// pwm_audio_decoder
//   Recovers 8-bit audio samples from a 1-bit PWM or first-order sigma-delta stream by counting
//   ones over a window of 2^WIN_LOG2 enabled clocks. The first window after reset is used only to
//   flush the input synchroniser and is never published.
//
// Parameters
//   WIN_LOG2     log2 of the window length in enabled clocks (8..12)
//   SYNC_STAGES  synchroniser flops on bit_in_i (0..3, 0 = use bit_in_i directly)
//
// Build option
//   PWM_DEC_AVG2_EN  when defined, each published sample is the average of the current and the
//                    previous window's value (clip still reflects the current window only).
//
// Ports
//   clk_i           clock
//   rst_ni          synchronous active-low reset
//   ena_i           design enable; low freezes all state and suppresses sample_valid_o
//   bit_in_i        1-bit PWM / sigma-delta stream, may be asynchronous
//   sample_out_o    last published sample
//   sample_valid_o  one-cycle strobe in the cycle sample_out_o updates
//   clip_o          last published window was all ones
module pwm_audio_decoder #(
    parameter int unsigned WIN_LOG2    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ena_i,
    input  logic       bit_in_i,
    output logic [7:0] sample_out_o,
    output logic       sample_valid_o,
    output logic       clip_o
);

    localparam int unsigned WinW = WIN_LOG2;
    localparam int unsigned CntW = WIN_LOG2 + 1;

    generate
        if (WIN_LOG2 < 8 || WIN_LOG2 > 12) begin : g_bad_win
            $error("pwm_audio_decoder: WIN_LOG2 must be in 8..12");
        end
        if (SYNC_STAGES > 3) begin : g_bad_sync
            $error("pwm_audio_decoder: SYNC_STAGES must be in 0..3");
        end
    endgenerate

    // Input synchroniser; shifts only on enabled cycles so ena_i freezes it too.
    logic bit_s;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign bit_s = bit_in_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    sync_q <= '0;
                end else if (ena_i) begin
                    sync_q <= SYNC_STAGES'({sync_q, bit_in_i});
                end
            end

            assign bit_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    typedef enum logic [0:0] {StPrime, StRun} state_e;

    state_e            state_q;
    logic [WinW-1:0]   win_cnt_q;
    logic [CntW-1:0]   ones_cnt_q;
    logic [7:0]        sample_q;
    logic              clip_q;
    logic              valid_q;

    logic              win_end;
    logic [CntW-1:0]   total;
    logic [CntW-1:0]   scaled;
    logic              sat;
    logic [7:0]        s_val;
    logic [7:0]        pub_val;

`ifdef PWM_DEC_AVG2_EN
    logic [7:0]        prev_q;
`endif

    always_comb begin
        win_end = ena_i & (&win_cnt_q);
        // Include the current bit so the window's last sample is not lost when the
        // accumulator clears on the same edge.
        total   = ones_cnt_q + CntW'(bit_s);
        scaled  = total >> (WIN_LOG2 - 8);
        // Since total never exceeds 2^WIN_LOG2, any bit above bit 7 after scaling
        // means the window was all ones.
        sat     = |scaled[CntW-1:8];
        s_val   = sat ? 8'hFF : scaled[7:0];
`ifdef PWM_DEC_AVG2_EN
        pub_val = 8'(({1'b0, s_val} + {1'b0, prev_q}) >> 1);
`else
        pub_val = s_val;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StPrime;
            win_cnt_q  <= '0;
            ones_cnt_q <= '0;
            sample_q   <= '0;
            clip_q     <= 1'b0;
            valid_q    <= 1'b0;
`ifdef PWM_DEC_AVG2_EN
            prev_q     <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (ena_i) begin
                win_cnt_q <= win_cnt_q + WinW'(1);
                if (win_end) begin
                    ones_cnt_q <= '0;
`ifdef PWM_DEC_AVG2_EN
                    prev_q     <= s_val;
`endif
                    unique case (state_q)
                        StPrime: state_q <= StRun;
                        StRun: begin
                            sample_q <= pub_val;
                            clip_q   <= sat;
                            valid_q  <= 1'b1;
                        end
                        default: state_q <= StPrime;
                    endcase
                end else begin
                    ones_cnt_q <= total;
                end
            end
        end
    end

    assign sample_out_o   = sample_q;
    assign sample_valid_o = valid_q;
    assign clip_o         = clip_q;

endmodule
